qtable_max_reader: RTL and testbench

- Reader side of the Q-table. The Q-value update datapath consumes `next_max`; this block produces it.
- Given a state index, it reads all action Q-values for that state from the Q-table RAM read port. It returns the maximum value (`next_max`) and the greedy action (argmax).
- Sits between the agent/episode controller and the Q-table RAM. Its `rsp_max` output feeds the update datapath's `next_max` input.
- Q-values are unsigned Q8.8: 16'h0100 = 1.0.

---
 rtl/qtable_max_reader.sv | 137 +++++++++++++
 tb/tb_qtable_max_reader.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qtable_max_reader.sv
// Q-table row scanner: reads every action Q-value of one state and returns the
// largest value (unsigned Q8.8) and its lowest-index argmax action.
module qtable_max_reader #(
    parameter int N_STATES  = 16,
    parameter int N_ACTIONS = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 6,
    parameter int STATE_W   = 4,
    parameter int ACT_W     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [STATE_W-1:0] req_state,
    output logic               mem_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_max,
    output logic [ACT_W-1:0]   rsp_action,
    output logic               rsp_err
);

    localparam logic [STATE_W:0]  N_STATES_EXT = (STATE_W + 1)'(N_STATES);
    localparam logic [ACT_W-1:0]  LAST_ACT     = ACT_W'(N_ACTIONS - 1);
    localparam logic [ADDR_W-1:0] ROW_LEN      = ADDR_W'(N_ACTIONS);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} fsm_t;

    fsm_t              state;
    logic [ACT_W-1:0]  act_p0;
    logic              vld_p1;
    logic [ACT_W-1:0]  act_p1;
    logic [DATA_W-1:0] best_p1;
    logic [ACT_W-1:0]  best_act_p1;
    logic [DATA_W-1:0] best_nxt;
    logic [ACT_W-1:0]  best_act_nxt;
    logic [ADDR_W-1:0] row_base;
    logic              out_of_range;

    // Strict greater-than keeps the lowest action on ties; action 0 always seeds the scan.
    function automatic logic takes_lead(input logic              first,
                                        input logic [DATA_W-1:0] cand,
                                        input logic [DATA_W-1:0] best);
        return first || (cand > best);
    endfunction

    assign row_base     = ADDR_W'(req_state) * ROW_LEN;
    assign out_of_range = {1'b0, req_state} >= N_STATES_EXT;

    always_comb begin
        best_nxt     = best_p1;
        best_act_nxt = best_act_p1;
        if (vld_p1 && takes_lead(act_p1 == '0, mem_rdata, best_p1)) begin
            best_nxt     = mem_rdata;
            best_act_nxt = act_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            act_p0      <= '0;
            vld_p1      <= 1'b0;
            act_p1      <= '0;
            best_p1     <= '0;
            best_act_p1 <= '0;
            rsp_valid   <= 1'b0;
            rsp_max     <= '0;
            rsp_action  <= '0;
            rsp_err     <= 1'b0;
        end else begin
            // p0 -> p1: read data returns one cycle after its enable
            vld_p1      <= mem_en;
            act_p1      <= act_p0;
            best_p1     <= best_nxt;
            best_act_p1 <= best_act_nxt;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (out_of_range) begin
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_max    <= '0;
                            rsp_action <= '0;
                            state      <= RESP;
                        end else begin
                            mem_en   <= 1'b1;
                            mem_addr <= row_base;
                            act_p0   <= '0;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (act_p0 == LAST_ACT) begin
                        mem_en <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        mem_en   <= 1'b1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        act_p0   <= act_p0 + ACT_W'(1);
                    end
                end
                DRAIN: begin
                    // The last word is still in flight; publish the merged result directly.
                    rsp_valid  <= 1'b1;
                    rsp_err    <= 1'b0;
                    rsp_max    <= best_nxt;
                    rsp_action <= best_act_nxt;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_en    <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qtable_max_reader.sv
// Randomized and directed scoreboard bench for qtable_max_reader, with a RAM
// model and a row-maximum reference computed from the stored Q-table.
module tb_qtable_max_reader;

    localparam int N_STATES  = 16;
    localparam int N_ACTIONS = 4;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 6;
    localparam int STATE_W   = 5;
    localparam int ACT_W     = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [STATE_W-1:0] req_state;
    logic               mem_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_rdata = '0;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_max;
    logic [ACT_W-1:0]   rsp_action;
    logic               rsp_err;

    qtable_max_reader #(
        .N_STATES (N_STATES),
        .N_ACTIONS(N_ACTIONS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .STATE_W  (STATE_W),
        .ACT_W    (ACT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_state (req_state),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_max   (rsp_max),
        .rsp_action(rsp_action),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] qmem [0:(1<<ADDR_W)-1];
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) mem_rdata <= qmem[mem_addr];
    end

    typedef struct {
        logic [DATA_W-1:0] max;
        logic [ACT_W-1:0]  act;
        logic              err;
        int                acc_cyc;
        int                lat;
    } exp_t;

    exp_t exp_q[$];
    int   addr_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   seen = 1'b0;
    logic [DATA_W-1:0] cap_max, last_max;
    logic [ACT_W-1:0]  cap_act, last_act;
    logic              cap_err, last_err;
    int   last_start = 0;
    int   prev_start = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: maximum of the row, then the first action holding that maximum.
    function automatic exp_t model(input int s, input int acc);
        exp_t e;
        int   mx;
        e.acc_cyc = acc;
        e.err     = 1'b0;
        e.act     = '0;
        if (s >= N_STATES) begin
            e.err = 1'b1;
            e.max = '0;
            e.lat = 1;
            return e;
        end
        mx = 0;
        for (int a = 0; a < N_ACTIONS; a++)
            if (int'(qmem[s*N_ACTIONS + a]) > mx) mx = int'(qmem[s*N_ACTIONS + a]);
        for (int a = N_ACTIONS - 1; a >= 0; a--)
            if (int'(qmem[s*N_ACTIONS + a]) == mx) e.act = ACT_W'(a);
        e.max = DATA_W'(mx);
        e.lat = N_ACTIONS + 2;
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                exp_q.delete();
                addr_q.delete();
                seen = 1'b0;
            end else begin
                if (req_valid && req_ready) begin
                    exp_q.push_back(model(int'(req_state), cyc));
                    if (int'(req_state) < N_STATES)
                        for (int a = 0; a < N_ACTIONS; a++)
                            addr_q.push_back(int'(req_state) * N_ACTIONS + a);
                end
                if (mem_en) begin
                    if (addr_q.size() == 0) check("mem_en_unexpected", 32'(mem_en), 32'd0);
                    else check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
                end
                if (rsp_valid) begin
                    check("req_ready_in_resp", 32'(req_ready), 32'd0);
                    if (!seen) begin
                        if (exp_q.size() == 0) begin
                            check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                        end else begin
                            seen       = 1'b1;
                            cap_max    = rsp_max;
                            cap_act    = rsp_action;
                            cap_err    = rsp_err;
                            prev_start = last_start;
                            last_start = cyc;
                            check("rsp_latency", 32'(cyc - exp_q[0].acc_cyc), 32'(exp_q[0].lat));
                        end
                    end else begin
                        check("hold_max", 32'(rsp_max), 32'(cap_max));
                        check("hold_action", 32'(rsp_action), 32'(cap_act));
                        check("hold_err", 32'(rsp_err), 32'(cap_err));
                    end
                    if (seen && rsp_ready) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("rsp_max", 32'(rsp_max), 32'(e.max));
                        check("rsp_action", 32'(rsp_action), 32'(e.act));
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        last_max = rsp_max;
                        last_act = rsp_action;
                        last_err = rsp_err;
                        seen     = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int s);
        int n;
        req_valid = 1'b1;
        req_state = STATE_W'(s);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        check("issue_accept", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_state = STATE_W'($urandom);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 40);
        check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("rsp_done_timeout", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic set_row(input int s, input logic [DATA_W-1:0] v0, input logic [DATA_W-1:0] v1,
                           input logic [DATA_W-1:0] v2, input logic [DATA_W-1:0] v3);
        qmem[s*N_ACTIONS + 0] = v0;
        qmem[s*N_ACTIONS + 1] = v1;
        qmem[s*N_ACTIONS + 2] = v2;
        qmem[s*N_ACTIONS + 3] = v3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold;
        int s;
        for (int i = 0; i < (1 << ADDR_W); i++) qmem[i] = DATA_W'($urandom);
        rst       = 1'b1;
        req_valid = 1'b0;
        req_state = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_mem_en", 32'(mem_en), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_max", 32'(rsp_max), 32'd0);
        check("reset_rsp_action", 32'(rsp_action), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        mon_en = 1'b1;
        tick();

        set_row(5, 16'h0080, 16'h01A0, 16'h0040, 16'h0100);
        issue(5);
        wait_done();
        check("s5_max", 32'(last_max), 32'h01A0);
        check("s5_action", 32'(last_act), 32'd1);
        check("s5_err", 32'(last_err), 32'd0);

        set_row(0, 16'h0200, 16'h0050, 16'h0200, 16'h0200);
        issue(0);
        wait_done();
        check("tie_max", 32'(last_max), 32'h0200);
        check("tie_action", 32'(last_act), 32'd0);

        set_row(3, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        issue(3);
        wait_done();
        check("zero_max", 32'(last_max), 32'h0000);
        check("zero_action", 32'(last_act), 32'd0);

        set_row(15, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
        issue(15);
        wait_done();
        check("s15_max", 32'(last_max), 32'hFFFF);
        check("s15_action", 32'(last_act), 32'd3);

        issue(16);
        wait_done();
        check("oor_err", 32'(last_err), 32'd1);
        check("oor_max", 32'(last_max), 32'd0);
        check("oor_action", 32'(last_act), 32'd0);

        rsp_ready = 1'b0;
        issue(7);
        wait_valid();
        tick();
        req_valid = 1'b1;
        req_state = STATE_W'(4);
        repeat (10) tick();
        req_valid = 1'b0;
        check("bp_still_valid", 32'(rsp_valid), 32'd1);
        tick();
        rsp_ready = 1'b1;
        wait_done();

        set_row(9, 16'h0300, 16'h0400, 16'h0500, 16'h0600);
        set_row(2, 16'h0011, 16'h0777, 16'h0777, 16'h0010);
        issue(9);
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_mem_en", 32'(mem_en), 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (8) begin
            @(negedge clk);
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        tick();
        issue(2);
        wait_done();
        check("after_rst_max", 32'(last_max), 32'h0777);
        check("after_rst_action", 32'(last_act), 32'd1);

        issue(1);
        issue(2);
        wait_done();
        check("b2b_spacing", 32'(last_start - prev_start), 32'd7);

        for (int it = 0; it < 30; it++) begin
            s = $urandom_range(0, N_STATES + 1);
            if (s < N_STATES) begin
                for (int a = 0; a < N_ACTIONS; a++) begin
                    case ($urandom_range(0, 3))
                        0:       qmem[s*N_ACTIONS + a] = 16'h0000;
                        1:       qmem[s*N_ACTIONS + a] = 16'h0100;
                        default: qmem[s*N_ACTIONS + a] = DATA_W'($urandom);
                    endcase
                end
            end
            hold = $urandom_range(0, 3);
            if (hold > 0) begin
                rsp_ready = 1'b0;
                issue(s);
                wait_valid();
                repeat (hold) tick();
                rsp_ready = 1'b1;
            end else begin
                issue(s);
            end
            wait_done();
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("addr_queue_empty", 32'(addr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
